// File: rtl/duck_hunt_pkg.sv
// Shared constants and types for the duck hunt sprite pipeline.
// Screen geometry, shape length, scheduler states and signed shape offsets.
package duck_hunt_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SHAPE_LEN = 13;
  localparam logic [2:0] BG_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    UPDATE,
    SETTLE,
    DRAW
  } sched_state_t;

  typedef logic signed [3:0] offset_t;

endpackage

// File: rtl/duck_shape_rom.sv
// Combinational duck outline: shape index k (0..12) to a signed (dx,dy) offset
// from the sprite head pixel.
module duck_shape_rom
  import duck_hunt_pkg::*;
(
  input  logic [3:0] k,
  output offset_t    dx,
  output offset_t    dy
);

  // Head, beak, body line and two pairs of splayed wings/tail feathers.
  always_comb begin
    dx = 4'sd0;
    dy = 4'sd0;
    case (k)
      4'd0:  begin dx =  4'sd0; dy =  4'sd0; end
      4'd1:  begin dx =  4'sd0; dy =  4'sd1; end
      4'd2:  begin dx = -4'sd1; dy =  4'sd0; end
      4'd3:  begin dx = -4'sd2; dy =  4'sd0; end
      4'd4:  begin dx = -4'sd3; dy =  4'sd0; end
      4'd5:  begin dx = -4'sd4; dy =  4'sd0; end
      4'd6:  begin dx = -4'sd5; dy =  4'sd0; end
      4'd7:  begin dx = -4'sd3; dy =  4'sd1; end
      4'd8:  begin dx = -4'sd3; dy = -4'sd1; end
      4'd9:  begin dx = -4'sd4; dy =  4'sd2; end
      4'd10: begin dx = -4'sd4; dy = -4'sd2; end
      4'd11: begin dx = -4'sd5; dy =  4'sd3; end
      4'd12: begin dx = -4'sd5; dy = -4'sd3; end
      default: begin dx = 4'sd0; dy = 4'sd0; end
    endcase
  end

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Per-frame erase / update / redraw sequencer; sole driver of the vga_adapter port.
// Optional macro SPRITE_CLIP_EN suppresses off-screen pixels; otherwise coordinates wrap.
module sprite_frame_scheduler
  import duck_hunt_pkg::*;
#(
  parameter int NUM_SPRITES = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     frame_tick,
  input  logic [NUM_SPRITES-1:0]   spr_active,
  input  logic [8*NUM_SPRITES-1:0] spr_x,
  input  logic [7*NUM_SPRITES-1:0] spr_y,
  input  logic [3*NUM_SPRITES-1:0] spr_colour,
  output logic                     upd_pulse,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic                     busy,
  output logic                     frame_overrun
);

  localparam int SW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SPRITES - 1);
  localparam logic [3:0] LAST_K = 4'(SHAPE_LEN - 1);

  sched_state_t state, state_next;
  logic [SW-1:0] slot;
  logic [3:0] k_idx;
  logic walking, last_pixel, use_live;

  logic [7:0] live_x [NUM_SPRITES];
  logic [6:0] live_y [NUM_SPRITES];
  logic [2:0] live_colour [NUM_SPRITES];
  logic [7:0] prev_x [NUM_SPRITES];
  logic [6:0] prev_y [NUM_SPRITES];
  logic [2:0] prev_colour [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] prev_active;

  offset_t dx, dy;
  logic [7:0] src_x, pix_x;
  logic [6:0] src_y, pix_y;
  logic [2:0] src_colour, pix_colour;
  logic src_active, pix_plot;

  duck_shape_rom u_shape (
    .k  (k_idx),
    .dx (dx),
    .dy (dy)
  );

  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      live_x[i]      = spr_x[8*i +: 8];
      live_y[i]      = spr_y[7*i +: 7];
      live_colour[i] = spr_colour[3*i +: 3];
    end
  end

  assign walking    = (state == ERASE) || (state == DRAW);
  assign last_pixel = (k_idx == LAST_K) && (slot == LAST_SLOT);
  assign busy       = (state != IDLE);
  assign upd_pulse  = (state == UPDATE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // A tick landing on the final DRAW pixel chains straight into the next frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick) state_next = ERASE;
      ERASE:   if (last_pixel) state_next = UPDATE;
      UPDATE:  state_next = SETTLE;
      SETTLE:  state_next = DRAW;
      DRAW:    if (last_pixel) state_next = frame_tick ? ERASE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      slot  <= '0;
      k_idx <= '0;
    end else if (walking && !last_pixel) begin
      if (k_idx == LAST_K) begin
        k_idx <= '0;
        slot  <= slot + 1'b1;
      end else begin
        k_idx <= k_idx + 4'd1;
      end
    end else begin
      slot  <= '0;
      k_idx <= '0;
    end
  end

  // The k=0 draw pixel reads the live inputs because the latch lands on that same edge.
  assign use_live   = (state == DRAW) && (k_idx == 4'd0);
  assign src_x      = use_live ? live_x[slot]      : prev_x[slot];
  assign src_y      = use_live ? live_y[slot]      : prev_y[slot];
  assign src_colour = use_live ? live_colour[slot] : prev_colour[slot];
  assign src_active = use_live ? spr_active[slot]  : prev_active[slot];
  assign pix_colour = (state == ERASE) ? BG_COLOUR : src_colour;

`ifdef SPRITE_CLIP_EN
  logic [8:0] full_x;
  logic [7:0] full_y;
  logic on_screen;

  always_comb begin
    full_x    = {1'b0, src_x} + {{5{dx[3]}}, dx};
    full_y    = {1'b0, src_y} + {{4{dy[3]}}, dy};
    on_screen = !full_x[8] && (full_x[7:0] < 8'(SCREEN_W)) &&
                !full_y[7] && (full_y[6:0] < 7'(SCREEN_H));
    pix_x     = full_x[7:0];
    pix_y     = full_y[6:0];
  end

  assign pix_plot = walking && src_active && on_screen;
`else
  assign pix_x    = src_x + {{4{dx[3]}}, dx};
  assign pix_y    = src_y + {{3{dy[3]}}, dy};
  assign pix_plot = walking && src_active;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_active <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        prev_x[i]      <= '0;
        prev_y[i]      <= '0;
        prev_colour[i] <= '0;
      end
    end else if (use_live) begin
      prev_x[slot]      <= live_x[slot];
      prev_y[slot]      <= live_y[slot];
      prev_colour[slot] <= live_colour[slot];
      prev_active[slot] <= spr_active[slot];
    end
  end

  // Coordinates and colour only move on plotted pixels so the adapter sees stable values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= pix_plot;
      if (pix_plot) begin
        vga_x      <= pix_x;
        vga_y      <= pix_y;
        vga_colour <= pix_colour;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      frame_overrun <= 1'b0;
    else if (frame_tick && busy && !((state == DRAW) && last_pixel))
      frame_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Randomised frame-level bench for sprite_frame_scheduler against a pixel-list model
// built from the duck outline table and the frame timing.
module tb_sprite_frame_scheduler;

  localparam int N = 4;
  localparam int HALF = 13 * N;
  localparam int FRAME = 26 * N + 2;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 1'b0;
  logic [N-1:0] spr_active = '0;
  logic [8*N-1:0] spr_x = '0;
  logic [7*N-1:0] spr_y = '0;
  logic [3*N-1:0] spr_colour = '0;
  logic upd_pulse, vga_plot, busy, frame_overrun;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  sprite_frame_scheduler #(.NUM_SPRITES(N)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .spr_active    (spr_active),
    .spr_x         (spr_x),
    .spr_y         (spr_y),
    .spr_colour    (spr_colour),
    .upd_pulse     (upd_pulse),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  always #5 clock = ~clock;

  int check_count = 0;
  int pass_count = 0;
  int shape_dx [13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int shape_dy [13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};
  int prev_x [N], prev_y [N], prev_c [N];
  bit prev_a [N];
  int nxt_x [N], nxt_y [N], nxt_c [N];
  bit nxt_a [N];
  bit exp_overrun = 1'b0;
  int erase_plots, draw_plots;

  task automatic check_output(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < N; i++) begin
      spr_x[8*i +: 8]      = 8'(nxt_x[i]);
      spr_y[7*i +: 7]      = 7'(nxt_y[i]);
      spr_colour[3*i +: 3] = 3'(nxt_c[i]);
      spr_active[i]        = nxt_a[i];
    end
  endtask

  function automatic void model_pixel(input int bx, input int by, input bit act, input int k,
                                      output bit plot, output int px, output int py);
    px = bx + shape_dx[k];
    py = by + shape_dy[k];
    plot = act;
`ifdef SPRITE_CLIP_EN
    if (px < 0 || px >= 160 || py < 0 || py >= 120) plot = 1'b0;
`endif
    px = px & 255;
    py = py & 127;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_plot"}, int'(vga_plot), 0);
    check_output({tag, "_x"}, int'(vga_x), 0);
    check_output({tag, "_y"}, int'(vga_y), 0);
    check_output({tag, "_colour"}, int'(vga_colour), 0);
    check_output({tag, "_upd"}, int'(upd_pulse), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_overrun"}, int'(frame_overrun), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      check_output("idle_plot", int'(vga_plot), 0);
      check_output("idle_busy", int'(busy), 0);
      check_output("idle_upd", int'(upd_pulse), 0);
    end
  endtask

  // One frame: tick, then compare every cycle until busy drops or the run is aborted by reset.
  task automatic run_frame(input int tick_at, input int abort_at);
    int drw_x [N], drw_y [N], drw_c [N];
    bit drw_a [N];
    bit ep;
    int ex, ey, ec, s, k;
    erase_plots = 0;
    draw_plots = 0;
    for (int i = 0; i < N; i++) begin
      drw_x[i] = nxt_x[i]; drw_y[i] = nxt_y[i]; drw_c[i] = nxt_c[i]; drw_a[i] = nxt_a[i];
    end
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    for (int t = 1; t <= FRAME; t++) begin
      @(negedge clock);
      ep = 1'b0; ex = 0; ey = 0; ec = 0;
      if (t <= HALF) begin
        s = (t - 1) / 13; k = (t - 1) % 13;
        model_pixel(prev_x[s], prev_y[s], prev_a[s], k, ep, ex, ey);
      end else if (t >= HALF + 3) begin
        s = (t - HALF - 3) / 13; k = (t - HALF - 3) % 13;
        model_pixel(drw_x[s], drw_y[s], drw_a[s], k, ep, ex, ey);
        ec = drw_c[s];
      end
      check_output("plot", int'(vga_plot), int'(ep));
      check_output("upd", int'(upd_pulse), int'(t == HALF));
      check_output("busy", int'(busy), int'(t < FRAME));
      if (ep) begin
        check_output("x", int'(vga_x), ex);
        check_output("y", int'(vga_y), ey);
        check_output("colour", int'(vga_colour), ec);
      end
      if (vga_plot && t <= HALF) erase_plots++;
      if (vga_plot && t > HALF) draw_plots++;
      if (t == HALF) apply_stimulus();
      if (t == tick_at) frame_tick = 1'b1;
      if (t == tick_at + 1) begin
        frame_tick = 1'b0;
        exp_overrun = 1'b1;
      end
      if (t == abort_at) begin
        resetn = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_overrun = 1'b0;
        for (int i = 0; i < N; i++) prev_a[i] = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
    end
    check_output("overrun", int'(frame_overrun), int'(exp_overrun));
    for (int i = 0; i < N; i++) begin
      prev_x[i] = drw_x[i]; prev_y[i] = drw_y[i]; prev_c[i] = drw_c[i]; prev_a[i] = drw_a[i];
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int c, input bit a);
    nxt_x[i] = x; nxt_y[i] = y; nxt_c[i] = c; nxt_a[i] = a;
  endtask

  task automatic randomise_slots(input bit keep_active, input bit [N-1:0] act);
    for (int i = 0; i < N; i++)
      set_slot(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 7)), keep_active ? act[i] : 1'($urandom_range(0, 1)));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      prev_x[i] = 0; prev_y[i] = 0; prev_c[i] = 0; prev_a[i] = 1'b0;
    end
    set_slot(0, 20, 30, 7, 1'b1);
    set_slot(1, 2, 1, 5, 1'b1);
    set_slot(2, 80, 60, 3, 1'b1);
    set_slot(3, 158, 118, 6, 1'b1);
    apply_stimulus();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    idle_cycles(3);

    run_frame(-1, -1);
    check_output("first_erase_plots", erase_plots, 0);
    idle_cycles(2);

    set_slot(0, 21, 30, 7, 1'b1);
    run_frame(-1, -1);
    check_output("second_erase_plots_min", int'(erase_plots >= 13), 1);
    idle_cycles(2);

    randomise_slots(1'b1, 4'b1111);
    run_frame(50, -1);
    idle_cycles(1);
    check_output("overrun_sticky", int'(frame_overrun), 1);

    randomise_slots(1'b1, 4'b1111);
    run_frame(-1, HALF + 3 + 20);
    idle_cycles(2);

    randomise_slots(1'b1, 4'b1111);
    run_frame(-1, -1);
    check_output("post_reset_erase_plots", erase_plots, 0);
    idle_cycles(1);

    randomise_slots(1'b1, 4'b0101);
    run_frame(-1, -1);
    randomise_slots(1'b1, 4'b0101);
    run_frame(-1, -1);
    idle_cycles(1);

    for (int f = 0; f < 6; f++) begin
      randomise_slots(1'b0, '0);
      run_frame(-1, -1);
      idle_cycles(int'($urandom_range(1, 4)));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
